fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller that drives a dual-port RAM directly upstream of it.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ptr.sv | 19 +
 rtl/fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_fifo_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO controller: default widths, pointer width helper
// and reset values of the status flags.
package fifo_pkg;

  localparam int unsigned ADDR_DEF = 4;
  localparam int unsigned DATA_DEF = 8;

  localparam logic RST_EMPTY  = 1'b1;
  localparam logic RST_FULL   = 1'b0;
  localparam logic RST_AEMPTY = 1'b1;
  localparam logic RST_AFULL  = 1'b0;

  // One extra pointer bit distinguishes full from empty when the addresses match.
  function automatic int unsigned ptr_w(input int unsigned addr);
    return addr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping W-bit pointer with increment enable and asynchronous active-low reset.
module fifo_ptr #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM (A = write, B = read).
// Define FIFO_CTRL_ALMOST_FLAGS_EN to add the registered almost_FULL/almost_EMPTY flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR = ADDR_DEF,
  parameter int unsigned DATA = DATA_DEF
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  ,
  parameter int unsigned AF_TH = 2,
  parameter int unsigned AE_TH = 2
`endif
) (
  input  logic            clK,
  input  logic            rstN,
  input  logic            wr_EN,
  input  logic [DATA-1:0] wr_DATA,
  input  logic            rd_EN,
  output logic [DATA-1:0] rd_DATA,
  output logic            rd_VALID,
  output logic            full,
  output logic            empty,
  output logic [ADDR:0]   count,
  output logic            ovf,
  output logic            udf,
  output logic            ram_a_WR,
  output logic [ADDR-1:0] ram_a_ADDR,
  output logic [DATA-1:0] ram_a_DATA,
  output logic            ram_b_WR,
  output logic [ADDR-1:0] ram_b_ADDR,
  input  logic [DATA-1:0] ram_b_DATA
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  ,
  output logic            almost_FULL,
  output logic            almost_EMPTY
`endif
);

  localparam int unsigned PW = ptr_w(ADDR);

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0] count_q, count_d;
  logic          push, pop;
  logic          full_q, full_d, empty_q, empty_d;
  logic          valid_q, ovf_q, udf_q;

  always_comb begin
    push       = wr_EN & ~full_q;
    pop        = rd_EN & ~empty_q;
    wr_ptr_nxt = wr_ptr + PW'(push);
    rd_ptr_nxt = rd_ptr + PW'(pop);
    empty_d    = (wr_ptr_nxt == rd_ptr_nxt);
    full_d     = (wr_ptr_nxt[ADDR-1:0] == rd_ptr_nxt[ADDR-1:0]) &&
                 (wr_ptr_nxt[ADDR] != rd_ptr_nxt[ADDR]);
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + PW'(1);
    end else if (pop && !push) begin
      count_d = count_q - PW'(1);
    end
  end

  fifo_ptr #(
    .W(PW)
  ) u_wr_ptr (
    .clk  (clK),
    .rst_n(rstN),
    .inc  (push),
    .ptr  (wr_ptr)
  );

  fifo_ptr #(
    .W(PW)
  ) u_rd_ptr (
    .clk  (clK),
    .rst_n(rstN),
    .inc  (pop),
    .ptr  (rd_ptr)
  );

  always_ff @(posedge clK or negedge rstN) begin
    if (!rstN) begin
      count_q <= '0;
      full_q  <= RST_FULL;
      empty_q <= RST_EMPTY;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      valid_q <= pop;
      // A rejected request only raises its pulse; pointers and count stay put.
      ovf_q   <= wr_EN & full_q;
      udf_q   <= rd_EN & empty_q;
    end
  end

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR;

  logic [PW-1:0] free_d;
  logic          afull_q, aempty_q;

  assign free_d = DEPTH - count_d;

  always_ff @(posedge clK or negedge rstN) begin
    if (!rstN) begin
      afull_q  <= RST_AFULL;
      aempty_q <= RST_AEMPTY;
    end else begin
      afull_q  <= (free_d <= PW'(AF_TH));
      aempty_q <= (count_d <= PW'(AE_TH));
    end
  end

  assign almost_FULL  = afull_q;
  assign almost_EMPTY = aempty_q;
`endif

  assign ram_a_WR   = push;
  assign ram_a_ADDR = wr_ptr[ADDR-1:0];
  assign ram_a_DATA = wr_DATA;
  assign ram_b_WR   = 1'b0;
  assign ram_b_ADDR = rd_ptr[ADDR-1:0];
  assign rd_DATA    = ram_b_DATA;
  assign rd_VALID   = valid_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed, table-driven bench for fifo_ctrl (ADDR=2, depth 4) with a registered-read RAM model.
module tb_fifo_ctrl;

  localparam int unsigned ADDR = 2;
  localparam int unsigned DATA = 8;

  logic            clK = 1'b0;
  logic            rstN = 1'b0;
  logic            wr_EN = 1'b0;
  logic [DATA-1:0] wr_DATA = '0;
  logic            rd_EN = 1'b0;
  logic [DATA-1:0] rd_DATA;
  logic            rd_VALID, full, empty, ovf, udf;
  logic [ADDR:0]   count;
  logic            ram_a_WR, ram_b_WR;
  logic [ADDR-1:0] ram_a_ADDR, ram_b_ADDR;
  logic [DATA-1:0] ram_a_DATA;
  logic [DATA-1:0] ram_b_DATA;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
  logic            almost_FULL, almost_EMPTY;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clK = ~clK;

  fifo_ctrl #(
    .ADDR(ADDR),
    .DATA(DATA)
  ) dut (
    .clK         (clK),
    .rstN        (rstN),
    .wr_EN       (wr_EN),
    .wr_DATA     (wr_DATA),
    .rd_EN       (rd_EN),
    .rd_DATA     (rd_DATA),
    .rd_VALID    (rd_VALID),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .ovf         (ovf),
    .udf         (udf),
    .ram_a_WR    (ram_a_WR),
    .ram_a_ADDR  (ram_a_ADDR),
    .ram_a_DATA  (ram_a_DATA),
    .ram_b_WR    (ram_b_WR),
    .ram_b_ADDR  (ram_b_ADDR),
    .ram_b_DATA  (ram_b_DATA)
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    ,
    .almost_FULL (almost_FULL),
    .almost_EMPTY(almost_EMPTY)
`endif
  );

  // Dual-port RAM: port A writes, port B has a registered read.
  logic [DATA-1:0] mem [4];
  always_ff @(posedge clK) begin
    if (ram_a_WR) mem[ram_a_ADDR] <= ram_a_DATA;
    ram_b_DATA <= mem[ram_b_ADDR];
  end

  typedef struct {
    logic            wr;
    logic            rd;
    logic [DATA-1:0] wd;
    logic            a_wr;
    logic [ADDR-1:0] a_addr;
    logic [ADDR:0]   cnt;
    logic            full;
    logic            empty;
    logic            vld;
    logic [DATA-1:0] rdat;
    logic            ovf;
    logic            udf;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] wd,
                              input logic a_wr, input logic [1:0] a_addr, input logic [2:0] cnt,
                              input logic f, input logic e, input logic v, input logic [7:0] rdat,
                              input logic o, input logic u);
    vec_t t;
    t.wr = wr; t.rd = rd; t.wd = wd; t.a_wr = a_wr; t.a_addr = a_addr; t.cnt = cnt;
    t.full = f; t.empty = e; t.vld = v; t.rdat = rdat; t.ovf = o; t.udf = u;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    // wr rd data  a_wr a_addr  cnt full empty vld rdat  ovf udf
    vecs[0]  = mk(1, 0, 8'h11, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    vecs[1]  = mk(1, 0, 8'h22, 1, 1, 2, 0, 0, 0, 8'h00, 0, 0);
    vecs[2]  = mk(1, 0, 8'h33, 1, 2, 3, 0, 0, 0, 8'h00, 0, 0);
    vecs[3]  = mk(1, 0, 8'h44, 1, 3, 4, 1, 0, 0, 8'h00, 0, 0);
    vecs[4]  = mk(1, 0, 8'h55, 0, 0, 4, 1, 0, 0, 8'h00, 1, 0);
    vecs[5]  = mk(0, 1, 8'h00, 0, 0, 3, 0, 0, 1, 8'h11, 0, 0);
    vecs[6]  = mk(0, 1, 8'h00, 0, 0, 2, 0, 0, 1, 8'h22, 0, 0);
    vecs[7]  = mk(0, 1, 8'h00, 0, 0, 1, 0, 0, 1, 8'h33, 0, 0);
    vecs[8]  = mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 1, 8'h44, 0, 0);
    vecs[9]  = mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 1);
    vecs[10] = mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
    vecs[11] = mk(1, 0, 8'hA0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    vecs[12] = mk(1, 0, 8'hA1, 1, 1, 2, 0, 0, 0, 8'h00, 0, 0);
    vecs[13] = mk(1, 1, 8'hB0, 1, 2, 2, 0, 0, 1, 8'hA0, 0, 0);
    vecs[14] = mk(1, 1, 8'hB1, 1, 3, 2, 0, 0, 1, 8'hA1, 0, 0);
    vecs[15] = mk(1, 1, 8'hB2, 1, 0, 2, 0, 0, 1, 8'hB0, 0, 0);
    vecs[16] = mk(1, 1, 8'hB3, 1, 1, 2, 0, 0, 1, 8'hB1, 0, 0);
    vecs[17] = mk(1, 1, 8'hB4, 1, 2, 2, 0, 0, 1, 8'hB2, 0, 0);
    vecs[18] = mk(1, 1, 8'hB5, 1, 3, 2, 0, 0, 1, 8'hB3, 0, 0);
    vecs[19] = mk(1, 0, 8'hC0, 1, 0, 3, 0, 0, 0, 8'h00, 0, 0);
    vecs[20] = mk(1, 0, 8'hC1, 1, 1, 4, 1, 0, 0, 8'h00, 0, 0);
    vecs[21] = mk(1, 1, 8'hC2, 0, 2, 3, 0, 0, 1, 8'hB4, 1, 0);
    vecs[22] = mk(0, 1, 8'h00, 0, 2, 2, 0, 0, 1, 8'hB5, 0, 0);
    vecs[23] = mk(0, 1, 8'h00, 0, 2, 1, 0, 0, 1, 8'hC0, 0, 0);
    vecs[24] = mk(0, 1, 8'h00, 0, 2, 0, 0, 1, 1, 8'hC1, 0, 0);
    vecs[25] = mk(1, 1, 8'hD0, 1, 2, 1, 0, 0, 0, 8'h00, 0, 1);
    vecs[26] = mk(1, 0, 8'hE0, 1, 3, 2, 0, 0, 0, 8'h00, 0, 0);
    vecs[27] = mk(1, 0, 8'hE1, 1, 0, 3, 0, 0, 0, 8'h00, 0, 0);
    vecs[28] = mk(1, 1, 8'hE2, 1, 1, 3, 0, 0, 1, 8'hD0, 0, 0);

    repeat (2) @(posedge clK);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_valid", 32'(rd_VALID), 0);
    check("rst_ovf_udf", {30'd0, ovf, udf}, 0);
    check("ram_b_wr", 32'(ram_b_WR), 0);
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    check("rst_aflags", {30'd0, almost_FULL, almost_EMPTY}, 32'd1);
`endif
    rstN = 1'b1;
    @(posedge clK);
    #1;

    for (int i = 0; i < NV; i++) begin
      wr_EN   = vecs[i].wr;
      rd_EN   = vecs[i].rd;
      wr_DATA = vecs[i].wd;
      #1;
      check($sformatf("v%0d_a_wr", i), 32'(ram_a_WR), 32'(vecs[i].a_wr));
      check($sformatf("v%0d_a_addr", i), 32'(ram_a_ADDR), 32'(vecs[i].a_addr));
      if (vecs[i].a_wr) check($sformatf("v%0d_a_data", i), 32'(ram_a_DATA), 32'(vecs[i].wd));
      @(posedge clK);
      #1;
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].full));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
      check($sformatf("v%0d_valid", i), 32'(rd_VALID), 32'(vecs[i].vld));
      check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("v%0d_udf", i), 32'(udf), 32'(vecs[i].udf));
      if (vecs[i].vld) check($sformatf("v%0d_rdata", i), 32'(rd_DATA), 32'(vecs[i].rdat));
    end

    // Asynchronous reset with count=3 and rd_VALID high, away from any clock edge.
    wr_EN = 1'b0;
    rd_EN = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_full", 32'(full), 0);
    check("arst_valid", 32'(rd_VALID), 0);
    check("arst_a_addr", 32'(ram_a_ADDR), 0);
    check("arst_b_addr", 32'(ram_b_ADDR), 0);
    #2;
    rstN = 1'b1;
    @(posedge clK);
    #1;

    // Refill after reset: old contents are gone, new data comes back in order.
    wr_EN   = 1'b1;
    wr_DATA = 8'hF0;
    @(posedge clK);
    #1;
    check("post_count1", 32'(count), 1);
    check("post_empty", 32'(empty), 0);
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    check("af_cnt1", 32'(almost_FULL), 0);
    check("ae_cnt1", 32'(almost_EMPTY), 1);
`endif
    wr_DATA = 8'hF1;
    @(posedge clK);
    #1;
    check("post_count2", 32'(count), 2);
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    check("af_cnt2", 32'(almost_FULL), 1);
    check("ae_cnt2", 32'(almost_EMPTY), 1);
`endif
    wr_DATA = 8'hF2;
    @(posedge clK);
    #1;
    check("post_count3", 32'(count), 3);
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    check("af_cnt3", 32'(almost_FULL), 1);
    check("ae_cnt3", 32'(almost_EMPTY), 0);
`endif
    wr_EN = 1'b0;
    rd_EN = 1'b1;
    @(posedge clK);
    #1;
    check("post_valid", 32'(rd_VALID), 1);
    check("post_rdata", 32'(rd_DATA), 32'h0000_00F0);
    check("post_count_pop", 32'(count), 2);
    rd_EN = 1'b0;
    @(posedge clK);
    #1;
    check("post_valid_drop", 32'(rd_VALID), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
